// File: rtl/starfield_pkg.sv
// Shared types and default geometry for the starfield sequencing controller.
package starfield_pkg;

   // Controller sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEED = 2'd1,
      SKIP = 2'd2,
      RUN  = 2'd3
   } sf_state_e;

   // Default screen and starfield geometry
   localparam int CORDW_DEF = 12;
   localparam int HRES_DEF  = 512;
   localparam int VRES_DEF  = 256;
   localparam int SPDW_DEF  = 4;

endpackage

// File: rtl/starfield_ctrl.sv
// Starfield LFSR sequencing controller.
// Steps the LFSR once per visible in-area pixel; during vertical blanking it
// reseeds the LFSR and pre-steps it by a per-frame offset so the stars scroll.
// Optional feature macro: STARFIELD_SCROLL_EN. When undefined the offset stays
// at zero, speed requests are discarded and the starfield is static.
module starfield_ctrl import starfield_pkg::*; #(
   parameter int CORDW      = CORDW_DEF,
   parameter int HRES       = HRES_DEF,
   parameter int VRES       = VRES_DEF,
   parameter int SPDW       = SPDW_DEF,
   parameter int SPEED_INIT = 1
) (
   input  logic             clk_pix,
   input  logic             rst,
   input  logic [CORDW-1:0] sx,
   input  logic [CORDW-1:0] sy,
   input  logic             de,
   input  logic             vbi,
   input  logic [SPDW-1:0]  cfg_speed,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   output logic             lfsr_en,
   output logic             lfsr_rst,
   output logic             sf_area,
   output logic             busy
);

   localparam int OFFW = $clog2(HRES);

   sf_state_e       state_q;
   logic [OFFW-1:0] offset_q;
   logic [OFFW-1:0] skip_cnt_q;
   logic            busy_q;
   logic [OFFW-1:0] step_s;
   logic [OFFW-1:0] offset_next_s;

   assign sf_area       = (sx < CORDW'(HRES)) && (sy < CORDW'(VRES));
   assign offset_next_s = offset_q + step_s;
   assign lfsr_rst      = rst || (state_q == SEED);
   assign busy          = busy_q;

   // LFSR step enable: free-running during pre-step, per visible pixel in RUN
   always_comb begin
      lfsr_en = 1'b0;
      case (state_q)
         SKIP:    lfsr_en = 1'b1;
         RUN:     lfsr_en = de && sf_area;
         default: lfsr_en = 1'b0;
      endcase
   end

   // Sequencer: vbi always restarts at SEED, even mid pre-step
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         state_q    <= IDLE;
         offset_q   <= '0;
         skip_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (vbi) begin
                  state_q <= SEED;
                  busy_q  <= 1'b1;
               end
            end
            SEED: begin
               offset_q   <= offset_next_s;
               skip_cnt_q <= offset_next_s;
               if (vbi) begin
                  state_q <= SEED;
                  busy_q  <= 1'b1;
               end else if (offset_next_s != '0) begin
                  state_q <= SKIP;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
               end
            end
            SKIP: begin
               skip_cnt_q <= skip_cnt_q - OFFW'(1);
               if (vbi) begin
                  state_q <= SEED;
                  busy_q  <= 1'b1;
               end else if (skip_cnt_q == OFFW'(1)) begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
               end
            end
            RUN: begin
               if (vbi) begin
                  state_q <= SEED;
                  busy_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

`ifdef STARFIELD_SCROLL_EN
   logic [SPDW-1:0]      speed_q;
   logic [SPDW-1:0]      pend_q;
   logic                 pend_vld_q;
   logic                 ready_q;
   logic [OFFW+SPDW-1:0] speed_ext_s;
   logic [OFFW+SPDW-1:0] pend_ext_s;

   // Zero-extend then keep the low bits: reduces speed mod HRES
   assign speed_ext_s = {{OFFW{1'b0}}, speed_q};
   assign pend_ext_s  = {{OFFW{1'b0}}, pend_q};
   assign step_s      = pend_vld_q ? pend_ext_s[OFFW-1:0] : speed_ext_s[OFFW-1:0];
   assign cfg_ready   = ready_q;

   // Speed handshake: one pending slot, consumed only by a SEED that saw it
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         speed_q    <= SPDW'(SPEED_INIT);
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         ready_q    <= 1'b1;
      end else if ((state_q == SEED) && pend_vld_q) begin
         speed_q    <= pend_q;
         pend_vld_q <= 1'b0;
         ready_q    <= 1'b1;
      end else if (cfg_valid && ready_q) begin
         pend_q     <= cfg_speed;
         pend_vld_q <= 1'b1;
         ready_q    <= 1'b0;
      end
   end
`else
   logic [SPDW-1:0] unused_cfg_s;
   logic            unused_vld_s;

   assign step_s       = '0;
   assign cfg_ready    = 1'b1;
   assign unused_cfg_s = cfg_speed ^ SPDW'(SPEED_INIT);
   assign unused_vld_s = cfg_valid;
`endif

endmodule

// File: tb/tb_starfield_ctrl.sv
// Self-checking bench for starfield_ctrl on a reduced raster (HRES=8, VRES=4).
module tb_starfield_ctrl;

   localparam int CORDW = 6, HRES = 8, VRES = 4, SPDW = 4, SPEED_INIT = 1;
   localparam int HTOT = 12, HACT = 10, LACT = 6, VBLANK = 15;
   localparam logic [15:0] SEEDV = 16'hACE1;
`ifdef STARFIELD_SCROLL_EN
   localparam bit SCROLL = 1'b1;
`else
   localparam bit SCROLL = 1'b0;
`endif

   logic             clk_pix = 1'b0;
   logic             rst = 1'b1;
   logic [CORDW-1:0] sx = '0, sy = '0;
   logic             de = 1'b0, vbi = 1'b0;
   logic [SPDW-1:0]  cfg_speed = '0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready, lfsr_en, lfsr_rst, sf_area, busy;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state (0 IDLE, 1 SEED, 2 SKIP, 3 RUN)
   int m_state, m_off, m_cnt, m_speed, m_pend;
   bit m_pv, m_ready;

   logic [4:0] exp_q[$];
   int         off_q[$];
   logic [15:0] lf_q;

   always #5 clk_pix = ~clk_pix;

   starfield_ctrl #(.CORDW(CORDW), .HRES(HRES), .VRES(VRES), .SPDW(SPDW),
                    .SPEED_INIT(SPEED_INIT)) dut (
      .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy), .de(de), .vbi(vbi),
      .cfg_speed(cfg_speed), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .lfsr_en(lfsr_en), .lfsr_rst(lfsr_rst), .sf_area(sf_area), .busy(busy));

   function automatic logic [15:0] lf_step(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [15:0] lf_adv(input logic [15:0] v, input int k);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < k; i++) r = lf_step(r);
      return r;
   endfunction

   function automatic int eo(input int o);
      return SCROLL ? o : 0;
   endfunction

   // LFSR driven by the controller, as in the display top
   always @(posedge clk_pix) begin
      if (rst || lfsr_rst) lf_q <= SEEDV;
      else if (lfsr_en)    lf_q <= lf_step(lf_q);
   end

   task automatic model_reset();
      m_state = 0; m_off = 0; m_cnt = 0; m_speed = SPEED_INIT; m_pend = 0;
      m_pv = 1'b0; m_ready = 1'b1;
   endtask

   task automatic model_step(input bit v, input bit cv, input int cs);
      bit xfer;
      int step;
      xfer = SCROLL && cv && m_ready;
      case (m_state)
         0: if (v) m_state = 1;
         1: begin
            step = SCROLL ? (m_pv ? m_pend : m_speed) : 0;
            if (m_pv) begin m_speed = m_pend; m_pv = 1'b0; m_ready = 1'b1; end
            m_off = (m_off + step) % HRES;
            m_cnt = m_off;
            m_state = v ? 1 : ((m_off != 0) ? 2 : 3);
         end
         2: begin
            if (v) m_state = 1;
            else if (m_cnt == 1) m_state = 3;
            m_cnt--;
         end
         default: if (v) m_state = 1;
      endcase
      if (xfer) begin m_pend = cs; m_pv = 1'b1; m_ready = 1'b0; end
   endtask

   task automatic cycle(input bit d, input int x, input int y, input bit v, input bit cv,
                        input int cs, output bit o_en, output bit o_bsy, output bit o_rs,
                        output logic [15:0] o_lf);
      logic [4:0] ev, ov;
      bit area;
      @(negedge clk_pix);
      de = d; sx = CORDW'(x); sy = CORDW'(y); vbi = v; cfg_valid = cv; cfg_speed = SPDW'(cs);
      area = (x < HRES) && (y < VRES);
      ev = {(m_state == 2) || (m_state == 3 && d && area), m_state == 1, area,
            (m_state == 1) || (m_state == 2), SCROLL ? m_ready : 1'b1};
      exp_q.push_back(ev);
      #1;
      ov = {lfsr_en, lfsr_rst, sf_area, busy, cfg_ready};
      ev = exp_q.pop_front();
      n_checks++;
      if (ov !== ev) begin
         n_fail++;
         $display("FAIL cycle_outputs x=%0d y=%0d {en,rst,area,busy,ready} got %b want %b",
                  x, y, ov, ev);
      end
      o_en = lfsr_en; o_bsy = busy; o_rs = lfsr_rst; o_lf = lf_q;
      @(posedge clk_pix);
      model_step(v, cv, cs);
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk_pix);
      rst = 1'b1; de = 1'b0; vbi = 1'b0; cfg_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_pix); #1;
         n_checks++;
         if ({lfsr_rst, lfsr_en, busy, cfg_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_outputs {rst,en,busy,ready} got %b want 1001",
                     {lfsr_rst, lfsr_en, busy, cfg_ready});
         end
      end
      @(negedge clk_pix);
      rst = 1'b0;
      @(posedge clk_pix);
      model_reset();
   endtask

   task automatic run_frame(input bit req_act, input bit req_seed, input int spd,
                            input bit vbi_skip);
      int skip_n, run_n, exp_off;
      bit en, bs, rs;
      logic [15:0] lf, lf_first;
      skip_n = 0; run_n = 0; lf_first = '0;
      cycle(1'b0, 0, LACT, 1'b1, 1'b0, 0, en, bs, rs, lf);
      for (int b = 0; b < VBLANK; b++) begin
         cycle(1'b0, b % 3, LACT + ((b > VBLANK / 2) ? 1 : 0), vbi_skip && (b == 1),
               req_seed && (b == 0), spd, en, bs, rs, lf);
         if (rs) skip_n = 0;
         else if (en && bs) skip_n++;
         else if (en) run_n++;
      end
      for (int y = 0; y < LACT; y++) begin
         for (int x = 0; x < HTOT; x++) begin
            cycle(x < HACT, x, y, 1'b0, req_act && (y >= 1), spd, en, bs, rs, lf);
            if (x == 0 && y == 0) lf_first = lf;
            if (en && !bs) run_n++;
         end
      end
      exp_off = off_q.pop_front();
      n_checks += 3;
      if (skip_n !== exp_off) begin
         n_fail++;
         $display("FAIL skip_count got %0d want %0d", skip_n, exp_off);
      end
      if (run_n !== HRES * VRES) begin
         n_fail++;
         $display("FAIL run_count got %0d want %0d", run_n, HRES * VRES);
      end
      if (lf_first !== lf_adv(SEEDV, exp_off)) begin
         n_fail++;
         $display("FAIL first_pixel_lfsr got %h want %h", lf_first, lf_adv(SEEDV, exp_off));
      end
   endtask

   task automatic test_reset();
      bit en, bs, rs;
      logic [15:0] lf;
      apply_reset(3);
      for (int i = 0; i < 1000; i++)
         cycle(1'b1, i % HTOT, (i / HTOT) % LACT, 1'b0, 1'b0, 0, en, bs, rs, lf);
   endtask

   task automatic test_first_frame();
      off_q.push_back(eo(1));
      run_frame(1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_speed_change();
      off_q.push_back(eo(2)); run_frame(1'b1, 1'b0, 5, 1'b0);
      off_q.push_back(eo(7)); run_frame(1'b0, 1'b0, 0, 1'b0);
      off_q.push_back(eo(4)); run_frame(1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_wrap_and_mod();
      bit en, bs, rs;
      logic [15:0] lf;
      apply_reset(2);
      cycle(1'b0, 0, LACT, 1'b0, 1'b1, 10, en, bs, rs, lf);
      cycle(1'b0, 0, LACT, 1'b0, 1'b1, 3, en, bs, rs, lf);
      cycle(1'b0, 0, LACT, 1'b0, 1'b0, 0, en, bs, rs, lf);
      off_q.push_back(eo(2)); run_frame(1'b0, 1'b0, 0, 1'b0);
      off_q.push_back(eo(4)); run_frame(1'b0, 1'b0, 0, 1'b0);
      off_q.push_back(eo(6)); run_frame(1'b0, 1'b0, 0, 1'b0);
      off_q.push_back(eo(0)); run_frame(1'b0, 1'b0, 0, 1'b0);
      off_q.push_back(eo(2)); run_frame(1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_seed_request();
      off_q.push_back(eo(4)); run_frame(1'b0, 1'b1, 3, 1'b0);
      off_q.push_back(eo(7)); run_frame(1'b0, 1'b0, 0, 1'b0);
      off_q.push_back(eo(2)); run_frame(1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_vbi_in_skip();
      apply_reset(2);
      off_q.push_back(eo(2)); run_frame(1'b0, 1'b0, 0, 1'b1);
      off_q.push_back(eo(3)); run_frame(1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_skip();
      bit en, bs, rs;
      logic [15:0] lf;
      apply_reset(2);
      cycle(1'b0, 0, LACT, 1'b0, 1'b1, 6, en, bs, rs, lf);
      cycle(1'b0, 0, LACT, 1'b1, 1'b0, 0, en, bs, rs, lf);
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, LACT, 1'b0, 1'b0, 0, en, bs, rs, lf);
      apply_reset(2);
      off_q.push_back(eo(1)); run_frame(1'b0, 1'b0, 0, 1'b0);
      off_q.push_back(eo(2)); run_frame(1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_first_frame();
      test_speed_change();
      test_wrap_and_mod();
      test_seed_request();
      test_vbi_in_skip();
      test_reset_mid_skip();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
